id_exe_stage_elastic: RTL

- Parametrised ID/EXE pipeline register with a valid/ready handshake on both sides.
- Includes a 2-entry skid buffer, a flush for bubble injection and a saturating stall counter.
- Sits between decode and execute.
- Lets execute back-pressure decode without a combinational ready path.
- Zeroes all side-effecting control when the stage holds a bubble.

---
 rtl/id_exe_stage_elastic.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/id_exe_stage_elastic.sv
// ---------------------------------------------------------------------------
// id_exe_stage_elastic
//
// ID/EXE pipeline register with valid/ready handshakes on both sides.
// A main register (M) drives the execute side. A one-entry skid register (S)
// catches the entry that decode hands over in the same cycle that execute
// stalls. Because of S, in_ready comes straight from a flop and never
// depends combinationally on out_ready.
//
// Ports
//   clk, rst            clock; synchronous active-high reset
//   flush               drop M, S and any entry accepted this cycle
//   in_valid/in_ready   decode-side handshake (in_ready = !S.valid)
//   *_in                decoded instruction payload and control
//   out_valid/out_ready execute-side handshake
//   *_out               registered payload; control bits gated by out_valid
//   stall_cnt           saturating count of out_valid && !out_ready cycles
// ---------------------------------------------------------------------------
module id_exe_stage_elastic #(
  parameter int DSIZE  = 16,
  parameter int ASIZE  = 3,
  parameter int ISIZE  = 16,
  parameter int OPSIZE = 4,
  parameter int CNTW   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DSIZE-1:0]  rdata1_in,
  input  logic [DSIZE-1:0]  rdata2_in,
  input  logic [DSIZE-1:0]  imm_in,
  input  logic [OPSIZE-1:0] opcode_in,
  input  logic              alusrc_in,
  input  logic [ASIZE-1:0]  waddr_in,
  input  logic              branch_in,
  input  logic              jal_in,
  input  logic              memRead_in,
  input  logic              memWrite_in,
  input  logic              memtoReg_in,
  input  logic              wen_in,
  input  logic [ISIZE-1:0]  pc_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DSIZE-1:0]  rdata1_out,
  output logic [DSIZE-1:0]  rdata2_out,
  output logic [DSIZE-1:0]  imm_out,
  output logic [OPSIZE-1:0] opcode_out,
  output logic              alusrc_out,
  output logic [ASIZE-1:0]  waddr_out,
  output logic [ISIZE-1:0]  pc_out,
  output logic              branch_out,
  output logic              jal_out,
  output logic              memRead_out,
  output logic              memWrite_out,
  output logic              memtoReg_out,
  output logic              wen_out,
  output logic [CNTW-1:0]   stall_cnt
);

  typedef struct packed {
    logic [DSIZE-1:0]  rdata1;
    logic [DSIZE-1:0]  rdata2;
    logic [DSIZE-1:0]  imm;
    logic [OPSIZE-1:0] opcode;
    logic              alusrc;
    logic [ASIZE-1:0]  waddr;
    logic [ISIZE-1:0]  pc;
    logic              branch;
    logic              jal;
    logic              mem_read;
    logic              mem_write;
    logic              memto_reg;
    logic              wen;
  } entry_t;

  function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
    logic [CNTW-1:0] one;
    one = {{(CNTW-1){1'b0}}, 1'b1};
    return (&v) ? v : v + one;
  endfunction

  entry_t          in_ent;
  entry_t          m_q, m_d;
  entry_t          s_q, s_d;
  logic            m_vld_q, m_vld_d;
  logic            s_vld_q, s_vld_d;
  logic [CNTW-1:0] stall_q, stall_d;
  logic            accept;
  logic            release_m;

  assign in_ent = '{
    rdata1:    rdata1_in,
    rdata2:    rdata2_in,
    imm:       imm_in,
    opcode:    opcode_in,
    alusrc:    alusrc_in,
    waddr:     waddr_in,
    pc:        pc_in,
    branch:    branch_in,
    jal:       jal_in,
    mem_read:  memRead_in,
    mem_write: memWrite_in,
    memto_reg: memtoReg_in,
    wen:       wen_in
  };

  // in_ready depends only on the skid flop, so it is a registered signal.
  assign in_ready  = !s_vld_q;
  assign accept    = in_valid && in_ready;
  assign release_m = m_vld_q && out_ready;

  always_comb begin
    m_d     = m_q;
    s_d     = s_q;
    m_vld_d = m_vld_q;
    s_vld_d = s_vld_q;
    stall_d = stall_q;

    if (m_vld_q && !out_ready) begin
      stall_d = sat_inc(stall_q);
    end

    if (flush) begin
      // Payload may stay stale; the gated control outputs hide it.
      m_vld_d = 1'b0;
      s_vld_d = 1'b0;
    end else if (!m_vld_q || release_m) begin
      // S always drains first to keep FIFO order; accept is impossible
      // while S is valid because in_ready is low then.
      if (s_vld_q) begin
        m_d     = s_q;
        m_vld_d = 1'b1;
        s_vld_d = 1'b0;
      end else if (accept) begin
        m_d     = in_ent;
        m_vld_d = 1'b1;
      end else begin
        m_vld_d = 1'b0;
      end
    end else if (accept) begin
      s_d     = in_ent;
      s_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_vld_q <= 1'b0;
      s_vld_q <= 1'b0;
      m_q     <= '0;
      stall_q <= '0;
    end else begin
      m_vld_q <= m_vld_d;
      s_vld_q <= s_vld_d;
      m_q     <= m_d;
      stall_q <= stall_d;
    end
  end

  // Skid payload is only observed through M after S.valid is set.
  always_ff @(posedge clk) begin
    s_q <= s_d;
  end

  assign out_valid    = m_vld_q;
  assign rdata1_out   = m_q.rdata1;
  assign rdata2_out   = m_q.rdata2;
  assign imm_out      = m_q.imm;
  assign opcode_out   = m_q.opcode;
  assign alusrc_out   = m_q.alusrc;
  assign waddr_out    = m_q.waddr;
  assign pc_out       = m_q.pc;
  assign branch_out   = m_q.branch    & m_vld_q;
  assign jal_out      = m_q.jal       & m_vld_q;
  assign memRead_out  = m_q.mem_read  & m_vld_q;
  assign memWrite_out = m_q.mem_write & m_vld_q;
  assign memtoReg_out = m_q.memto_reg & m_vld_q;
  assign wen_out      = m_q.wen       & m_vld_q;
  assign stall_cnt    = stall_q;

endmodule
